// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and constants for the fetch PC generator
//
// Purpose : holds the pc_gen FSM state encoding, the fetch/BPU request
//           struct and the default reset fetch address.
// Contents: pc_gen_state_t  BOOT / RUN / REFILL
//           fetch_req_t     {valid, pc}
//           bpu_query_req_t same layout as fetch_req_t, sent to the BPU
//           PC_GEN_RESET_PC default first fetch address
package pc_gen_pkg;

  localparam logic [31:0] PC_GEN_RESET_PC = 32'h8000_0000;

  // Sequential fetch step in bytes (one 32-bit instruction).
  localparam logic [31:0] PC_GEN_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    REFILL = 2'd2
  } pc_gen_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } fetch_req_t;

  // The BPU query carries exactly what the fetch request carries.
  typedef fetch_req_t bpu_query_req_t;

  // Word-align an address by clearing the two low bits.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with zero-bubble BPU prediction
//
// Purpose : produces the instruction fetch address stream. Every accepted
//           fetch queries the BPU; the BPU answer (or pc+4) arrives the next
//           cycle and is used directly as the next fetch address, so both
//           sequential and predicted-taken fetch run without bubbles.
//           Backend redirects override everything and cost one bubble.
// Ports   : clk, rst (async, active-high)
//           redirect_valid/redirect_pc   backend redirect in
//           bpu_query (valid, pc)        query to BPU, bpu_flush to BPU
//           predict_valid/predict_target BPU answer for the last query
//           fetch_valid/fetch_pc/fetch_ready  I-cache request handshake
//           pred_valid/pred_pc/pred_npc/pred_taken  resolved prediction out
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_GEN_RESET_PC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           redirect_valid,
  input  logic [31:0]    redirect_pc,
  output bpu_query_req_t bpu_query,
  output logic           bpu_flush,
  input  logic           predict_valid,
  input  logic [31:0]    predict_target,
  output logic           fetch_valid,
  output logic [31:0]    fetch_pc,
  input  logic           fetch_ready,
  output logic           pred_valid,
  output logic [31:0]    pred_pc,
  output logic [31:0]    pred_npc,
  output logic           pred_taken
);

  pc_gen_state_t state_q, state_d;
  logic [31:0]   pc_q, pc_d;                 // held fetch address when no query is pending
  logic [31:0]   last_pc_q, last_pc_d;       // address of the most recent fire
  logic          query_pending_q, query_pending_d;

  logic [31:0]   seq_pc;
  logic [31:0]   resolved;
  logic          fire;

  // Successor of the last fired pc: BPU target if taken, else pc+4 (wraps).
  assign seq_pc   = last_pc_q + PC_GEN_STEP;
  assign resolved = predict_valid ? predict_target : seq_pc;

  // While a query is pending the BPU answer is consumed in the same cycle,
  // giving back-to-back fetch. Otherwise replay the held address.
  assign fetch_pc    = query_pending_q ? resolved : pc_q;
  assign fetch_valid = (state_q == RUN) && !redirect_valid;
  assign fire        = fetch_valid && fetch_ready;

  assign bpu_query.valid = fire;
  assign bpu_query.pc    = fetch_pc;
  assign bpu_flush       = redirect_valid;

  // A prediction is reported only in the cycle its BPU answer is live; a
  // redirect in that cycle kills it.
  assign pred_valid = query_pending_q && !redirect_valid;
  assign pred_pc    = last_pc_q;
  assign pred_npc   = resolved;
  assign pred_taken = predict_valid;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    last_pc_d       = last_pc_q;
    query_pending_d = query_pending_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      REFILL:  state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (redirect_valid) begin
      // Redirect wins in every state; consecutive redirects overwrite pc.
      state_d         = REFILL;
      pc_d            = pc_align(redirect_pc);
      query_pending_d = 1'b0;
    end else if (fire) begin
      last_pc_d       = fetch_pc;
      query_pending_d = 1'b1;
    end else if (state_q == RUN) begin
      // Stalled: capture the (possibly just-resolved) address so it stays
      // stable while fetch_valid is held and the BPU answer is not needed again.
      pc_d            = fetch_pc;
      query_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      last_pc_q       <= 32'h0;
      query_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      last_pc_q       <= last_pc_d;
      query_pending_q <= query_pending_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           redirect_valid = 1'b0;
  logic [31:0]    redirect_pc = 32'h0;
  bpu_query_req_t bpu_query;
  logic           bpu_flush;
  logic           predict_valid = 1'b0;
  logic [31:0]    predict_target = 32'h0;
  logic           fetch_valid;
  logic [31:0]    fetch_pc;
  logic           fetch_ready = 1'b1;
  logic           pred_valid;
  logic [31:0]    pred_pc;
  logic [31:0]    pred_npc;
  logic           pred_taken;

  int checks = 0;
  int failures = 0;

  pc_gen #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bpu_query      (bpu_query),
    .bpu_flush      (bpu_flush),
    .predict_valid  (predict_valid),
    .predict_target (predict_target),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_npc       (pred_npc),
    .pred_taken     (pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] redir_pc;
    logic        pv;
    logic [31:0] pt;
    logic        rdy;
    logic        e_fv;
    logic [31:0] e_fpc;
    logic        e_pv;
    logic [31:0] e_ppc;
    logic [31:0] e_npc;
    logic        e_tk;
    logic        e_flush;
    logic        e_qv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rs, input logic rd, input logic [31:0] rpc,
    input logic pv, input logic [31:0] pt, input logic rdy,
    input logic fv, input logic [31:0] fpc,
    input logic pvo, input logic [31:0] ppc, input logic [31:0] npc, input logic tk,
    input logic fl, input logic qv);
    vec_t v;
    v.rst = rs; v.redir = rd; v.redir_pc = rpc; v.pv = pv; v.pt = pt; v.rdy = rdy;
    v.e_fv = fv; v.e_fpc = fpc; v.e_pv = pvo; v.e_ppc = ppc; v.e_npc = npc;
    v.e_tk = tk; v.e_flush = fl; v.e_qv = qv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs away from the rising edge, then let comb settle.
  task automatic drive(input logic rs, input logic rd, input logic [31:0] rpc,
                       input logic pv, input logic [31:0] pt, input logic rdy);
    @(negedge clk);
    rst = rs; redirect_valid = rd; redirect_pc = rpc;
    predict_valid = pv; predict_target = pt; fetch_ready = rdy;
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    drive(v.rst, v.redir, v.redir_pc, v.pv, v.pt, v.rdy);
    chk($sformatf("v%0d.fetch_valid", idx), {31'b0, fetch_valid}, {31'b0, v.e_fv});
    chk($sformatf("v%0d.fetch_pc", idx), fetch_pc, v.e_fpc);
    chk($sformatf("v%0d.pred_valid", idx), {31'b0, pred_valid}, {31'b0, v.e_pv});
    chk($sformatf("v%0d.bpu_flush", idx), {31'b0, bpu_flush}, {31'b0, v.e_flush});
    chk($sformatf("v%0d.bpu_query_valid", idx), {31'b0, bpu_query.valid}, {31'b0, v.e_qv});
    if (v.e_qv)
      chk($sformatf("v%0d.bpu_query_pc", idx), bpu_query.pc, v.e_fpc);
    if (v.e_pv) begin
      chk($sformatf("v%0d.pred_pc", idx), pred_pc, v.e_ppc);
      chk($sformatf("v%0d.pred_npc", idx), pred_npc, v.e_npc);
      chk($sformatf("v%0d.pred_taken", idx), {31'b0, pred_taken}, {31'b0, v.e_tk});
    end
  endtask

  int pulses;

  initial begin
    //               rst redir rpc           pv pt            rdy  fv fpc           pv ppc           npc           tk fl qv
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1,   0, 32'h8000_0000, 0, 32'h0,         32'h0,         0, 0, 0)); // in reset
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   0, 32'h8000_0000, 0, 32'h0,         32'h0,         0, 0, 0)); // BOOT
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8000_0000, 0, 32'h0,         32'h0,         0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8000_0004, 1, 32'h8000_0000, 32'h8000_0004, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h8000_0100,  1,   1, 32'h8000_0100, 1, 32'h8000_0004, 32'h8000_0100, 1, 0, 1)); // taken, no bubble
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8000_0104, 1, 32'h8000_0100, 32'h8000_0104, 0, 0, 1));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,          1,   0, 32'h8000_0000, 0, 32'h0,         32'h0,         0, 0, 0)); // reset with pending query
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   0, 32'h8000_0000, 0, 32'h0,         32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8000_0000, 0, 32'h0,         32'h0,         0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8000_0004, 1, 32'h8000_0000, 32'h8000_0004, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8000_0008, 1, 32'h8000_0004, 32'h8000_0008, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h8000_0200,  0,   1, 32'h8000_0200, 1, 32'h8000_0008, 32'h8000_0200, 1, 0, 0)); // stall 1
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h8000_0200, 0, 32'h0,         32'h0,         0, 0, 0)); // stall 2
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h8000_0200, 0, 32'h0,         32'h0,         0, 0, 0)); // stall 3
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8000_0200, 0, 32'h0,         32'h0,         0, 0, 1)); // fires
    vecs.push_back(mk(0, 1, 32'h8000_1003,  0, 32'h0,          1,   0, 32'h8000_0204, 0, 32'h0,         32'h0,         0, 1, 0)); // redirect kills pred
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   0, 32'h8000_1000, 0, 32'h0,         32'h0,         0, 0, 0)); // REFILL bubble
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8000_1000, 0, 32'h0,         32'h0,         0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,          1,   1, 32'h8000_1004, 1, 32'h8000_1000, 32'h8000_1004, 0, 0, 1));

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Back-to-back redirects (second lands in REFILL): last one wins.
    drive(0, 1, 32'h1000_0000, 0, 32'h0, 1);
    chk("rr1.fetch_valid", {31'b0, fetch_valid}, 32'h0);
    drive(0, 1, 32'hFFFF_FFFF, 0, 32'h0, 1);
    chk("rr2.bpu_flush", {31'b0, bpu_flush}, 32'h1);
    drive(0, 0, 32'h0, 0, 32'h0, 1);
    chk("rr3.bubble", {31'b0, fetch_valid}, 32'h0);
    chk("rr3.fetch_pc", fetch_pc, 32'hFFFF_FFFC);
    drive(0, 0, 32'h0, 0, 32'h0, 1);
    chk("wrap.fire_valid", {31'b0, bpu_query.valid}, 32'h1);
    chk("wrap.fire_pc", fetch_pc, 32'hFFFF_FFFC);
    // Sequential successor of FFFF_FFFC wraps to zero.
    drive(0, 0, 32'h0, 0, 32'h0, 1);
    chk("wrap.fetch_pc", fetch_pc, 32'h0000_0000);
    chk("wrap.pred_npc", pred_npc, 32'h0000_0000);

    // Long stall with the BPU answer held: address constant, one pred pulse.
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 32'h0, 1, 32'h0000_0040, 0);
      if (pred_valid) pulses++;
      chk($sformatf("stall%0d.fetch_pc", c), fetch_pc, 32'h0000_0040);
      chk($sformatf("stall%0d.fetch_valid", c), {31'b0, fetch_valid}, 32'h1);
    end
    chk("stall.pred_pulses", pulses, 32'd1);

    // Reset mid-stream: first fetch is RESET_PC on the second cycle after release.
    drive(1, 0, 32'h0, 1, 32'h0000_0040, 1);
    chk("rst.fetch_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst.pred_valid", {31'b0, pred_valid}, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0, 1);
    chk("rel1.fetch_valid", {31'b0, fetch_valid}, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0, 1);
    chk("rel2.fetch_valid", {31'b0, fetch_valid}, 32'h1);
    chk("rel2.fetch_pc", fetch_pc, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port redirect_valid  input  1: backend mispredict/exception redirect.
REQ-005 SHALL have port redirect_pc  input  32: redirect target; bits [1:0] forced to 0.
REQ-006 SHALL have port bpu_query  output  bpu_query_req_t: fields valid and pc, driven to the BPU.
REQ-007 SHALL have port bpu_flush  output  1: equal to redirect_valid.
REQ-008 SHALL have port predict_valid  input  1: BPU taken prediction for the last queried pc.
REQ-009 SHALL have port predict_target  input  32: BPU predicted target.
REQ-010 SHALL have port fetch_valid  output  1: fetch request valid.
REQ-011 SHALL have port fetch_pc  output  32: fetch request address.
REQ-012 SHALL have port fetch_ready  input  1: I-cache accepts the request; fire = fetch_valid & fetch_ready.
REQ-013 SHALL have port pred_valid  output  1: prediction resolved for pred_pc this cycle.
REQ-014 SHALL have port pred_pc  output  32: pc whose successor is reported.
REQ-015 SHALL have port pred_npc  output  32: predicted successor pc.
REQ-016 SHALL have port pred_taken  output  1: pred_npc came from the BPU.

Function
REQ-017 SHALL implement an FSM with states BOOT, RUN and REFILL; reset enters BOOT; BOOT->RUN after one cycle; RUN->REFILL on redirect_valid; REFILL->RUN after one cycle; redirect_valid in BOOT or REFILL stays in or enters REFILL.
REQ-018 SHALL hold registers pc_r, last_pc and query_pending.
REQ-019 SHALL compute resolved = predict_valid ? predict_target : last_pc+4, with the add wrapping mod 2^32.
REQ-020 SHALL drive fetch_pc = query_pending ? resolved : pc_r.
REQ-021 SHALL assert fetch_valid only in RUN when redirect_valid=0.
REQ-022 SHALL assert bpu_query.valid = fire and bpu_query.pc = fetch_pc.
REQ-023 On fire: last_pc<=fetch_pc, query_pending<=1; this gives zero-bubble sequential and predicted-taken fetch.
REQ-024 On no fire in RUN without redirect: pc_r<=fetch_pc, query_pending<=0, so fetch_pc stays stable while fetch_valid is held.
REQ-025 pred_valid SHALL equal query_pending & ~redirect_valid, with pred_pc=last_pc, pred_npc=resolved and pred_taken=predict_valid.
REQ-026 On redirect_valid (highest priority, any state): pc_r<={redirect_pc[31:2],2'b00}, query_pending<=0, no fire, no BPU query that cycle.
REQ-027 SHALL use REFILL as a one-cycle bubble after redirect; fetch resumes from the redirect pc on the following cycle.
REQ-028 If redirect_valid is asserted in consecutive cycles, the last redirect_pc wins.
REQ-029 With fetch_ready held low indefinitely, fetch_pc and fetch_valid SHALL stay constant and pred_valid SHALL pulse at most once.
REQ-030 pc_r=32'hFFFF_FFFC followed by a sequential fire SHALL wrap the next fetch_pc to 0.

Reset
REQ-031 While rst=1: state=BOOT, pc_r=RESET_PC, last_pc=0, query_pending=0, fetch_valid=0, bpu_query.valid=0, pred_valid=0.
REQ-032 Reset asserted mid-stream SHALL discard any pending prediction immediately; the first fetch_pc after release is RESET_PC, on the second cycle after release.

Structure
REQ-033 The bundle package SHALL hold the pc_gen_state_t enum (BOOT/RUN/REFILL), the fetch_req_t struct (valid, pc) and the RESET_PC default; bpu_query_req_t SHALL be reused from it.
REQ-034 No sub-module; the PC adder and muxes are local logic.

Verification
REQ-035 Reset release, ready=1, no prediction -> fetch_pc 8000_0000, 8000_0004, 8000_0008 on consecutive cycles, with pred_valid and pred_npc lagging one cycle.
REQ-036 predict_valid=1 with target 8000_0100 in the cycle after fire of 8000_0004 -> next fetch_pc=8000_0100 with no bubble; pred_taken=1 and pred_pc=8000_0004.
REQ-037 fetch_ready=0 for 3 cycles after fire of 8000_0008 while the BPU predicts 8000_0200 -> fetch_pc holds 8000_0200 for all 3 cycles, pred_valid pulses once, and 8000_0200 fires when ready returns.
REQ-038 redirect_valid with redirect_pc=8000_1003 in the same cycle as a pending prediction -> pred_valid=0, bpu_flush=1, one bubble cycle, then fetch_pc=8000_1000.
REQ-039 Reset asserted while query_pending=1 -> all outputs zero or inactive; after release fetch restarts at RESET_PC.
REQ-040 pc_r=FFFF_FFFC fires with no prediction -> next fetch_pc=0000_0000.
